clock_ctrl: RTL and testbench

CLOCK_CTRL -- requirements
Module: clock_ctrl

---
 rtl/clock_ctrl.sv | 125 ++++++++++++
 tb/tb_clock_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_ctrl.sv
// rtl/clock_ctrl.sv - Clock set/run controller: button sync, 1 s prescaler, mode FSM, counter enables
module clock_ctrl #(
    parameter int PRESCALE = 50_000_000
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       sec_ca,
    input  logic       min_ca,
    output logic       sec_cen,
    output logic       min_cen,
    output logic       hour_cen,
    output logic       min_inc,
    output logic       hour_inc,
    output logic [1:0] mode,
    output logic       blink_min,
    output logic       blink_hour
);
    localparam int PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] C_LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] C_HALF = PW'(PRESCALE / 2 - 1);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_SET_MIN  = 2'd1,
        S_SET_HOUR = 2'd2,
        S_BAD      = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [PW-1:0] r_cnt;
    logic          r_blink;
    logic          r_mode_s1;
    logic          r_mode_s2;
    logic          r_mode_q;
    logic          r_up_s1;
    logic          r_up_s2;
    logic          r_up_q;
    logic          w_mode_evt;
    logic          w_up_evt;
    logic          w_tick;
    logic          w_half_tick;
    logic          w_restart;
    logic          w_enter_set;

    // Two-flop synchronizers followed by a rising-edge flop per button
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_mode_s1 <= 1'b0;
            r_mode_s2 <= 1'b0;
            r_mode_q  <= 1'b0;
            r_up_s1   <= 1'b0;
            r_up_s2   <= 1'b0;
            r_up_q    <= 1'b0;
        end else begin
            r_mode_s1 <= btn_mode;
            r_mode_s2 <= r_mode_s1;
            r_mode_q  <= r_mode_s2;
            r_up_s1   <= btn_up;
            r_up_s2   <= r_up_s1;
            r_up_q    <= r_up_s2;
        end
    end

    assign w_mode_evt  = r_mode_s2 & ~r_mode_q;
    assign w_up_evt    = r_up_s2 & ~r_up_q;
    assign w_tick      = (r_cnt == C_LAST);
    assign w_half_tick = (r_cnt == C_LAST) || (r_cnt == C_HALF);
    assign w_restart   = (r_state == S_SET_HOUR) && w_mode_evt;

    // Leaving SET_HOUR restarts the second so the first tick is a full period away
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_cnt <= '0;
        end else if (w_restart || w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN:      if (w_mode_evt) w_state_nxt = S_SET_MIN;
            S_SET_MIN:  if (w_mode_evt) w_state_nxt = S_SET_HOUR;
            S_SET_HOUR: if (w_mode_evt) w_state_nxt = S_RUN;
            default:    w_state_nxt = S_RUN;
        endcase
    end

    assign w_enter_set = w_mode_evt &&
                         ((w_state_nxt == S_SET_MIN) || (w_state_nxt == S_SET_HOUR));

    // Entering a set state starts with the digits visible for a full half period
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_blink <= 1'b0;
        end else if (w_enter_set) begin
            r_blink <= 1'b1;
        end else if (w_half_tick) begin
            r_blink <= ~r_blink;
        end
    end

    assign sec_cen    = w_tick & (r_state == S_RUN);
    assign min_cen    = sec_ca & (r_state == S_RUN);
    assign hour_cen   = min_ca & (r_state == S_RUN);
    assign min_inc    = w_up_evt & (r_state == S_SET_MIN) & ~w_mode_evt;
    assign hour_inc   = w_up_evt & (r_state == S_SET_HOUR) & ~w_mode_evt;
    assign mode       = r_state;
    assign blink_min  = r_blink & (r_state == S_SET_MIN);
    assign blink_hour = r_blink & (r_state == S_SET_HOUR);

endmodule

// File: tb/tb_clock_ctrl.sv
// tb/tb_clock_ctrl.sv - Randomized model-checked bench for clock_ctrl with directed literal pins
module tb_clock_ctrl;
    localparam int P = 4;

    logic       clk;
    logic       n_rst;
    logic       btn_mode;
    logic       btn_up;
    logic       sec_ca;
    logic       min_ca;
    logic       sec_cen;
    logic       min_cen;
    logic       hour_cen;
    logic       min_inc;
    logic       hour_inc;
    logic [1:0] mode;
    logic       blink_min;
    logic       blink_hour;

    clock_ctrl #(.PRESCALE(P)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .btn_mode  (btn_mode),
        .btn_up    (btn_up),
        .sec_ca    (sec_ca),
        .min_ca    (min_ca),
        .sec_cen   (sec_cen),
        .min_cen   (min_cen),
        .hour_cen  (hour_cen),
        .min_inc   (min_inc),
        .hour_inc  (hour_inc),
        .mode      (mode),
        .blink_min (blink_min),
        .blink_hour(blink_hour)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: state as an integer, time since the last second restart,
    // and the last three sampled button levels (index 0 = newest edge).
    int m_state = 0;
    int m_since = 0;
    bit m_blink = 0;
    bit m_valid = 0;
    bit hm0 = 0, hm1 = 0, hm2 = 0;
    bit hu0 = 0, hu1 = 0, hu2 = 0;

    always @(posedge clk) begin
        bit mevt;
        int ns;
        mevt = hm1 && !hm2;
        m_valid <= 1'b1;
        if (!n_rst) begin
            m_state <= 0;
            m_since <= 0;
            m_blink <= 1'b0;
            hm0 <= 0; hm1 <= 0; hm2 <= 0;
            hu0 <= 0; hu1 <= 0; hu2 <= 0;
        end else begin
            ns = mevt ? (m_state + 1) % 3 : m_state;
            m_state <= ns;
            m_since <= (m_state == 2 && mevt) ? 0 : (m_since + 1) % P;
            if (mevt && ns != 0)
                m_blink <= 1'b1;
            else if (m_since % (P / 2) == P / 2 - 1)
                m_blink <= !m_blink;
            hm2 <= hm1; hm1 <= hm0; hm0 <= btn_mode;
            hu2 <= hu1; hu1 <= hu0; hu0 <= btn_up;
        end
    end

    always @(negedge clk) begin
        bit mevt, uevt, run;
        if (m_valid) begin
            mevt = hm1 && !hm2;
            uevt = hu1 && !hu2;
            run  = (m_state == 0);
            check("sec_cen",    sec_cen,    (m_since == P - 1) && run);
            check("min_cen",    min_cen,    sec_ca && run);
            check("hour_cen",   hour_cen,   min_ca && run);
            check("min_inc",    min_inc,    uevt && m_state == 1 && !mevt);
            check("hour_inc",   hour_inc,   uevt && m_state == 2 && !mevt);
            check("mode",       mode,       m_state);
            check("blink_min",  blink_min,  m_blink && m_state == 1);
            check("blink_hour", blink_hour, m_blink && m_state == 2);
        end
    end

    int n_sec = 0, n_minc = 0, n_hinc = 0;

    // Returns just after a negedge; inputs are driven there, outputs read there.
    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            n_sec  += int'(sec_cen);
            n_minc += int'(min_inc);
            n_hinc += int'(hour_inc);
            #1;
        end
    endtask

    task automatic press_mode();
        btn_mode = 1'b1;
        run_cycles(4);
        btn_mode = 1'b0;
        run_cycles(3);
    endtask

    initial begin
        bit seen;
        int hold_m, hold_u;
        n_rst = 1'b0; btn_mode = 1'b0; btn_up = 1'b0; sec_ca = 1'b0; min_ca = 1'b0;
        run_cycles(3);
        n_rst = 1'b1;
        check("rst_mode",  mode, 0);
        check("rst_cen",   {sec_cen, min_cen, hour_cen}, 0);
        check("rst_inc",   {min_inc, hour_inc}, 0);
        check("rst_blink", {blink_min, blink_hour}, 0);

        n_sec = 0;
        for (int j = 1; j <= 12; j++) begin
            run_cycles(1);
            check("sec_cen_pattern", sec_cen, (j % 4 == 3));
            check("idle_min_cen", min_cen, 0);
        end
        check("idle_sec_count", n_sec, 3);

        sec_ca = 1'b1; min_ca = 1'b1;
        #1;
        check("carry_min_cen",  min_cen, 1);
        check("carry_hour_cen", hour_cen, 1);
        run_cycles(1);
        sec_ca = 1'b0; min_ca = 1'b0;
        run_cycles(2);

        btn_mode = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            run_cycles(1);
            if (!seen && mode == 2'd1) begin
                seen = 1;
                check("blink_min_on_entry", blink_min, 1);
            end
        end
        btn_mode = 1'b0;
        n_sec = 0;
        run_cycles(8);
        check("one_transition", mode, 1);
        check("set_min_no_sec", n_sec, 0);

        n_minc = 0; n_hinc = 0;
        for (int k = 0; k < 3; k++) begin
            btn_up = 1'b1;
            run_cycles(3);
            btn_up = 1'b0;
            run_cycles(3);
        end
        check("min_inc_count",  n_minc, 3);
        check("min_hour_inc_0", n_hinc, 0);

        press_mode();
        check("to_set_hour", mode, 2);
        n_minc = 0; n_hinc = 0;
        btn_up = 1'b1;
        run_cycles(3);
        btn_up = 1'b0;
        run_cycles(3);
        check("hour_inc_count", n_hinc, 1);
        check("hour_min_inc_0", n_minc, 0);

        n_hinc = 0;
        btn_mode = 1'b1; btn_up = 1'b1;
        for (int i = 0; i < 10; i++) begin
            run_cycles(1);
            if (mode == 2'd0) break;
        end
        check("coincide_mode", mode, 0);
        check("coincide_no_inc", n_hinc, 0);
        run_cycles(1);
        check("restart_k1", sec_cen, 0);
        run_cycles(1);
        check("restart_k2", sec_cen, 0);
        run_cycles(1);
        check("restart_k3", sec_cen, 1);
        btn_mode = 1'b0; btn_up = 1'b0;
        run_cycles(3);

        press_mode();
        press_mode();
        check("reach_set_hour", mode, 2);
        btn_up = 1'b1;
        run_cycles(1);
        n_rst = 1'b0;
        run_cycles(1);
        n_rst = 1'b1;
        check("midrst_mode",  mode, 0);
        check("midrst_blink", {blink_min, blink_hour}, 0);
        check("midrst_inc",   {min_inc, hour_inc}, 0);
        btn_up = 1'b0;
        n_sec = 0;
        run_cycles(12);
        check("resume_sec_count", n_sec, 3);

        hold_m = 0; hold_u = 0;
        for (int c = 0; c < 3000; c++) begin
            if (hold_m == 0) begin
                btn_mode = 1'($urandom_range(0, 1));
                hold_m = $urandom_range(1, 7);
            end else begin
                hold_m--;
            end
            if (hold_u == 0) begin
                btn_up = 1'($urandom_range(0, 1));
                hold_u = $urandom_range(1, 5);
            end else begin
                hold_u--;
            end
            sec_ca = ($urandom_range(0, 7) == 0);
            min_ca = ($urandom_range(0, 15) == 0);
            n_rst  = ($urandom_range(0, 399) != 0);
            run_cycles(1);
        end
        n_rst = 1'b1; btn_mode = 1'b0; btn_up = 1'b0; sec_ca = 1'b0; min_ca = 1'b0;
        run_cycles(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
